// File: rtl/udp_user_pkg.sv
// Shared types and widths for the UDP user-side blocks.
package udp_user_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    START,
    SEND,
    WAIT_DONE
  } state_e;

endpackage

// File: rtl/udp_echo_ram.sv
// Simple dual-port word buffer: synchronous write, registered read.
module udp_echo_ram
  import udp_user_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Write port and registered read port; rdata holds when re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/udp_echo_buf.sv
// Loopback peer of the UDP engine: buffers one received payload, then echoes it back.
module udp_echo_buf
  import udp_user_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_en,
  input  logic [WORD_W-1:0] rec_data,
  input  logic              rec_pkt_done,
  input  logic [LEN_W-1:0]  rec_byte_num,
  output logic              tx_start_en,
  output logic [LEN_W-1:0]  tx_byte_num,
  input  logic              tx_req,
  output logic [WORD_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic [LEN_W-1:0]  drop_cnt
);

  // One extra bit so byte lengths up to 16'hFFFF+3 and word counts compare without wrap.
  localparam int unsigned    PW        = LEN_W + 1;
  localparam logic [AW:0]    WR_FULL   = (AW + 1)'(DEPTH_WORDS);
  localparam logic [AW:0]    PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0]  MAX_BYTES = PW'(DEPTH_WORDS * 4);
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W - 1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  drop_q;
  // Set when the last request fell past the payload; forces tx_data to zero.
  logic              zero_q, zero_d;
  logic              drop_inc;
  logic              ram_we, ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic [PW-1:0]     n_words;
  logic              rd_in_range;
  logic              ovf_now;
  logic              have_words;
  logic              bad_len;

  assign n_words     = (PW'(len_q) + PW'(3)) >> 2;
  assign rd_in_range = PW'(rd_ptr_q) < n_words;

  udp_echo_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(rec_data),
    .re   (ram_re),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(ram_rdata)
  );

  // Next-state logic: receive into buffer, validate, then serve engine read requests.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    len_d      = len_q;
    zero_d     = zero_q;
    drop_inc   = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ovf_now    = 1'b0;
    have_words = 1'b0;
    bad_len    = 1'b0;
    unique case (state_q)
      IDLE, RECV: begin
        if (rec_en) begin
          if (wr_ptr_q == WR_FULL) begin
            ovf_now = 1'b1;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
          ovf_d = ovf_q | ovf_now;
          if (state_q == IDLE) begin
            state_d = RECV;
          end
        end
        // A done pulse only ends a packet if at least one word arrived.
        have_words = (state_q == RECV) || rec_en;
        bad_len    = (rec_byte_num == '0) || (PW'(rec_byte_num) > MAX_BYTES);
        if (rec_pkt_done && have_words) begin
          if (ovf_q || ovf_now || bad_len) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
          end else begin
            len_d   = rec_byte_num;
            state_d = START;
          end
        end
      end
      START: begin
        drop_inc = rec_pkt_done;
        rd_ptr_d = '0;
        state_d  = SEND;
      end
      SEND, WAIT_DONE: begin
        drop_inc = rec_pkt_done;
        if (tx_req) begin
          zero_d = !rd_in_range;
          if (rd_in_range) begin
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end
        end
        if ((state_q == SEND) && (PW'(rd_ptr_d) == n_words)) begin
          state_d = WAIT_DONE;
        end
        if (tx_done) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointers, length latch and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      len_q    <= '0;
      drop_q   <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      len_q    <= len_d;
      zero_q   <= zero_d;
      if (drop_inc && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_ONE;
      end
    end
  end

  assign tx_start_en = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign tx_byte_num = len_q;
  assign drop_cnt    = drop_q;
  assign tx_data     = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_udp_echo_buf.sv
// Bench for udp_echo_buf: packet-level reference model plus directed scenarios.
module tb_udp_echo_buf;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req = 1'b0;
  logic [31:0] tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [15:0] drop_cnt;

  udp_echo_buf #(
    .DEPTH_WORDS(DEPTH),
    .AW         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rec_en      (rec_en),
    .rec_data    (rec_data),
    .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int start_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: phase 0 idle, 1 collecting, 2 announcing, 3 echoing.
  int          m_phase = 0;
  logic [31:0] m_words[$];
  bit          m_ovf = 1'b0;
  bit          m_had = 1'b0;
  int          m_idx = 0;
  logic [15:0] m_len = '0;
  logic [15:0] m_drop = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_words.delete();
      m_ovf   = 1'b0;
      m_idx   = 0;
      m_len   = '0;
      m_drop  = '0;
      m_data  = '0;
    end else begin
      case (m_phase)
        0, 1: begin
          m_had = (m_phase == 1) || rec_en;
          if (rec_en) begin
            if (m_words.size() < DEPTH) m_words.push_back(rec_data);
            else m_ovf = 1'b1;
            m_phase = 1;
          end
          if (rec_pkt_done && m_had) begin
            if (m_ovf || rec_byte_num == 0 || int'(rec_byte_num) > DEPTH * 4) begin
              if (m_drop != 16'hFFFF) m_drop++;
              m_phase = 0;
              m_words.delete();
              m_ovf = 1'b0;
            end else begin
              m_len   = rec_byte_num;
              m_phase = 2;
            end
          end
        end
        2: begin
          if (rec_pkt_done && m_drop != 16'hFFFF) m_drop++;
          m_idx   = 0;
          m_phase = 3;
        end
        default: begin
          if (rec_pkt_done && m_drop != 16'hFFFF) m_drop++;
          if (tx_req) begin
            if (m_idx < (int'(m_len) + 3) / 4) begin
              m_data = m_words[m_idx];
              m_idx++;
            end else begin
              m_data = '0;
            end
          end
          if (tx_done) begin
            m_phase = 0;
            m_words.delete();
            m_ovf = 1'b0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_phase != 0);
      chk("tx_start_en", tx_start_en, m_phase == 2);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("tx_byte_num", tx_byte_num, m_len);
      chk("tx_data", tx_data, m_data);
      if (tx_start_en) start_cnt++;
    end
  end

  logic [31:0] pkt[$];
  logic [31:0] got[$];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic rx_pkt(input int nbytes, input bit same_cycle);
    for (int i = 0; i < pkt.size(); i++) begin
      rec_en   = 1'b1;
      rec_data = pkt[i];
      if (same_cycle && i == pkt.size() - 1) begin
        rec_pkt_done = 1'b1;
        rec_byte_num = 16'(nbytes);
      end
      cyc();
    end
    rec_en = 1'b0;
    if (!same_cycle) begin
      rec_pkt_done = 1'b1;
      rec_byte_num = 16'(nbytes);
      cyc();
    end
    rec_pkt_done = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_start_en) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_start: got no tx_start_en expected a pulse within 20 cycles");
    end
  endtask

  task automatic serve(input int nreq);
    bit ok;
    got.delete();
    wait_start(ok);
    if (!ok) return;
    cyc();
    for (int i = 0; i < nreq; i++) begin
      tx_req = 1'b1;
      cyc();
      tx_req = 1'b0;
      got.push_back(tx_data);
      cyc();
    end
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bit ok;
    do_reset();
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_len", tx_byte_num, 0);
    chk("rst_start", tx_start_en, 0);

    // Done pulse with no words in idle is ignored.
    rec_pkt_done = 1'b1;
    rec_byte_num = 16'd4;
    cyc();
    rec_pkt_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_drop", drop_cnt, 0);

    // 8-byte packet.
    s0 = start_cnt;
    pkt = '{32'h11223344, 32'h55667788};
    rx_pkt(8, 1'b0);
    chk("t1_len", tx_byte_num, 16'd8);
    serve(2);
    chk("t1_w0", got[0], 32'h11223344);
    chk("t1_w1", got[1], 32'h55667788);
    chk("t1_starts", start_cnt - s0, 1);

    // 5-byte packet, last word with done in the same cycle, extra request reads zero.
    pkt = '{32'hAABBCCDD, 32'hEE000000};
    rx_pkt(5, 1'b1);
    chk("t2_len", tx_byte_num, 16'd5);
    serve(3);
    chk("t2_w0", got[0], 32'hAABBCCDD);
    chk("t2_w1", got[1], 32'hEE000000);
    chk("t2_w2", got[2], 32'h0);
    chk("t2_idle", busy, 0);

    // Oversize packet is dropped.
    do_reset();
    s0 = start_cnt;
    pkt.delete();
    for (int i = 0; i < 257; i++) pkt.push_back(32'(i + 1));
    rx_pkt(1025, 1'b1);
    chk("t3_busy", busy, 0);
    chk("t3_drop", drop_cnt, 16'd1);
    cyc();
    chk("t3_starts", start_cnt - s0, 0);

    // Second packet during SEND is dropped, first echoes intact.
    do_reset();
    s0 = start_cnt;
    pkt = '{32'h01020304};
    rx_pkt(4, 1'b0);
    wait_start(ok);
    cyc();
    rec_en = 1'b1;
    rec_data = 32'hDEADBEEF;
    cyc();
    rec_en = 1'b0;
    rec_pkt_done = 1'b1;
    rec_byte_num = 16'd4;
    cyc();
    rec_pkt_done = 1'b0;
    tx_req = 1'b1;
    cyc();
    tx_req = 1'b0;
    chk("t4_word", tx_data, 32'h01020304);
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    repeat (3) cyc();
    chk("t4_drop", drop_cnt, 16'd1);
    chk("t4_busy", busy, 0);
    chk("t4_starts", start_cnt - s0, 1);

    // Reset mid-SEND, then a normal 4-byte echo.
    pkt = '{32'hCAFEF00D, 32'h12345678};
    rx_pkt(8, 1'b0);
    wait_start(ok);
    cyc();
    tx_req = 1'b1;
    cyc();
    tx_req = 1'b0;
    chk("t5_pre", tx_data, 32'hCAFEF00D);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_data", tx_data, 0);
    chk("t5_len", tx_byte_num, 0);
    chk("t5_start", tx_start_en, 0);
    chk("t5_drop", drop_cnt, 0);
    pkt = '{32'h0BADC0DE};
    rx_pkt(4, 1'b0);
    serve(1);
    chk("t5_echo", got[0], 32'h0BADC0DE);

    // Zero-length packet dropped, then back-to-back echoes in order.
    do_reset();
    s0 = start_cnt;
    pkt = '{32'h11111111};
    rx_pkt(0, 1'b0);
    chk("t6_drop", drop_cnt, 16'd1);
    chk("t6_busy", busy, 0);
    pkt = '{32'hA1A2A3A4};
    rx_pkt(4, 1'b0);
    serve(1);
    chk("t6_a", got[0], 32'hA1A2A3A4);
    pkt = '{32'hB1B2B3B4, 32'hB5B6B7B8};
    rx_pkt(7, 1'b0);
    chk("t6_len", tx_byte_num, 16'd7);
    serve(2);
    chk("t6_b0", got[0], 32'hB1B2B3B4);
    chk("t6_b1", got[1], 32'hB5B6B7B8);
    chk("t6_starts", start_cnt - s0, 2);

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
